// File: rtl/cordic_rotate_if.sv
// rtl/cordic_rotate_if.sv - start/done operand and result bundle for cordic_rotate
interface cordic_rotate_if;
  logic        i_start;
  logic [31:0] ix;
  logic [31:0] iy;
  logic [31:0] iz;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_x;
  logic [31:0] o_y;
  logic [31:0] o_z;

  modport master (
    output i_start, ix, iy, iz,
    input  o_busy, o_done, o_x, o_y, o_z
  );

  modport slave (
    input  i_start, ix, iy, iz,
    output o_busy, o_done, o_x, o_y, o_z
  );
endinterface

// File: rtl/cordic_rotate.sv
// rtl/cordic_rotate.sv - iterative circular CORDIC, rotation mode, one micro-rotation per clock
module cordic_rotate #(
  parameter int ITERATION = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  cordic_rotate_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ROT, OUT} state_t;

  state_t             state, state_nxt;
  logic signed [33:0] x_r, y_r;
  logic        [31:0] z_r;
  logic        [4:0]  cnt;
  logic        [31:0] o_x_r, o_y_r, o_z_r;
  logic               start_cap;
  logic               last_step;
  logic               fold;
  logic               d_pos;
  logic signed [33:0] x_sh, y_sh;
  logic signed [33:0] ix_ext, iy_ext;
  logic        [31:0] atan_i;

  function automatic logic [31:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:  atan_lut = 32'h20000000;
      5'd1:  atan_lut = 32'h12E4051E;
      5'd2:  atan_lut = 32'h09FB385B;
      5'd3:  atan_lut = 32'h051111D4;
      5'd4:  atan_lut = 32'h028B0D43;
      5'd5:  atan_lut = 32'h0145D7E1;
      5'd6:  atan_lut = 32'h00A2F61E;
      5'd7:  atan_lut = 32'h00517C55;
      5'd8:  atan_lut = 32'h0028BE53;
      5'd9:  atan_lut = 32'h00145F2F;
      5'd10: atan_lut = 32'h000A2F98;
      5'd11: atan_lut = 32'h000517CC;
      5'd12: atan_lut = 32'h00028BE6;
      5'd13: atan_lut = 32'h000145F3;
      5'd14: atan_lut = 32'h0000A2FA;
      5'd15: atan_lut = 32'h0000517D;
      5'd16: atan_lut = 32'h000028BE;
      5'd17: atan_lut = 32'h0000145F;
      5'd18: atan_lut = 32'h00000A30;
      5'd19: atan_lut = 32'h00000518;
      5'd20: atan_lut = 32'h0000028C;
      5'd21: atan_lut = 32'h00000146;
      5'd22: atan_lut = 32'h000000A3;
      5'd23: atan_lut = 32'h00000051;
      5'd24: atan_lut = 32'h00000029;
      5'd25: atan_lut = 32'h00000014;
      5'd26: atan_lut = 32'h0000000A;
      5'd27: atan_lut = 32'h00000005;
      5'd28: atan_lut = 32'h00000003;
      5'd29: atan_lut = 32'h00000001;
      default: atan_lut = 32'h00000000;
    endcase
  endfunction

  // Clamp the 34-bit guard-banded value into the 32-bit signed output range.
  function automatic logic [31:0] sat34(input logic signed [33:0] v);
    if (v[33:31] == 3'b000 || v[33:31] == 3'b111)
      sat34 = v[31:0];
    else if (v[33])
      sat34 = 32'h80000000;
    else
      sat34 = 32'h7FFFFFFF;
  endfunction

  assign start_cap = bus.i_start && (state != ROT);
  assign last_step = (cnt == 5'(ITERATION));
  assign fold      = bus.iz[31] ^ bus.iz[30];
  assign ix_ext    = signed'({{2{bus.ix[31]}}, bus.ix});
  assign iy_ext    = signed'({{2{bus.iy[31]}}, bus.iy});
  assign d_pos     = ~z_r[31];
  assign x_sh      = x_r >>> cnt;
  assign y_sh      = y_r >>> cnt;
  assign atan_i    = atan_lut(cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_start) state_nxt = ROT;
      ROT:     if (last_step)   state_nxt = OUT;
      OUT:     state_nxt = bus.i_start ? ROT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r   <= '0;
      y_r   <= '0;
      z_r   <= '0;
      cnt   <= '0;
      o_x_r <= '0;
      o_y_r <= '0;
      o_z_r <= '0;
    end else if (start_cap) begin
      // Angles in quadrants 2/3 are folded by 180 deg so the iteration range covers them.
      x_r <= fold ? -ix_ext : ix_ext;
      y_r <= fold ? -iy_ext : iy_ext;
      z_r <= fold ? (bus.iz ^ 32'h80000000) : bus.iz;
      cnt <= '0;
    end else if (state == ROT) begin
      if (last_step) begin
        o_x_r <= sat34(x_r);
        o_y_r <= sat34(y_r);
        o_z_r <= z_r;
      end else begin
        x_r <= d_pos ? (x_r - y_sh) : (x_r + y_sh);
        y_r <= d_pos ? (y_r + x_sh) : (y_r - x_sh);
        z_r <= d_pos ? (z_r - atan_i) : (z_r + atan_i);
        cnt <= cnt + 5'd1;
      end
    end
  end

  assign bus.o_busy = (state == ROT);
  assign bus.o_done = (state == OUT);
  assign bus.o_x    = o_x_r;
  assign bus.o_y    = o_y_r;
  assign bus.o_z    = o_z_r;

endmodule

// File: tb/tb_cordic_rotate.sv
// tb/tb_cordic_rotate.sv - randomized self-checking bench for cordic_rotate against a trig model
module tb_cordic_rotate;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  real  k_gain;

  localparam longint TOL  = 64'h8000;
  localparam longint UNIT = 64'h26DD3B6A;

  cordic_rotate_if bus ();

  cordic_rotate #(.ITERATION(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Ideal rotation by the unsigned binary angle, scaled by the CORDIC gain and clamped.
  function automatic void model(input longint x, input longint y, input logic [31:0] z,
                                output longint ex, output longint ey);
    real ang, rx, ry;
    ang = real'(longint'({32'd0, z})) * 2.0 * 3.14159265358979323846 / 4294967296.0;
    rx  = k_gain * (real'(x) * $cos(ang) - real'(y) * $sin(ang));
    ry  = k_gain * (real'(x) * $sin(ang) + real'(y) * $cos(ang));
    if (rx > 2147483647.0) rx = 2147483647.0;
    if (rx < -2147483648.0) rx = -2147483648.0;
    if (ry > 2147483647.0) ry = 2147483647.0;
    if (ry < -2147483648.0) ry = -2147483648.0;
    ex = longint'(rx);
    ey = longint'(ry);
  endfunction

  function automatic longint absdiff(input logic [31:0] act, input longint exp);
    longint a;
    a = longint'(signed'(act)) - exp;
    return (a < 0) ? -a : a;
  endfunction

  task automatic start_op(input longint x, input longint y, input logic [31:0] z);
    bus.i_start = 1'b1;
    bus.ix      = x[31:0];
    bus.iy      = y[31:0];
    bus.iz      = z;
    @(posedge clk);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      bus.i_start = 1'b0;
      if (bus.o_done || lat >= 40) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b required 0 0", bus.o_busy, bus.o_done);
    end
    checks++;
    if (bus.o_x !== 32'd0 || bus.o_y !== 32'd0 || bus.o_z !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs x=%h y=%h z=%h required 0", bus.o_x, bus.o_y, bus.o_z);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rotation;
    logic [31:0] angles [4] = '{32'h00000000, 32'h40000000, 32'h80000000, 32'hE0000000};
    longint ex, ey;
    int lat;
    logic [31:0] hold_x;
    for (int i = 0; i < 4; i++) begin
      model(UNIT, 0, angles[i], ex, ey);
      start_op(UNIT, 0, angles[i]);
      wait_done(lat);
      checks++;
      if (lat != 17) begin
        errors++;
        $display("FAIL rot_latency angle=%h got %0d required 17", angles[i], lat);
      end
      checks++;
      if (absdiff(bus.o_x, ex) > TOL || absdiff(bus.o_y, ey) > TOL) begin
        errors++;
        $display("FAIL rot_value angle=%h got x=%h y=%h required x~%h y~%h",
                 angles[i], bus.o_x, bus.o_y, ex[31:0], ey[31:0]);
      end
      if (angles[i] == 32'hE0000000) begin
        checks++;
        if (absdiff(bus.o_z, 0) >= 64'h10000) begin
          errors++;
          $display("FAIL rot_residual got z=%h required |z|<10000", bus.o_z);
        end
      end
      hold_x = bus.o_x;
      @(negedge clk);
      checks++;
      if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_x !== hold_x) begin
        errors++;
        $display("FAIL done_width done=%b busy=%b x=%h required 0 0 %h",
                 bus.o_done, bus.o_busy, bus.o_x, hold_x);
      end
    end
  endtask

  task automatic test_random;
    longint x, y, ex, ey;
    logic [31:0] z;
    int lat;
    for (int i = 0; i < 12; i++) begin
      x = longint'($urandom_range(32'h20000000)) - 64'h10000000;
      y = longint'($urandom_range(32'h20000000)) - 64'h10000000;
      z = $urandom;
      model(x, y, z, ex, ey);
      start_op(x, y, z);
      wait_done(lat);
      checks++;
      if (lat != 17 || absdiff(bus.o_x, ex) > TOL || absdiff(bus.o_y, ey) > TOL) begin
        errors++;
        $display("FAIL random z=%h lat=%0d got x=%h y=%h required lat=17 x~%h y~%h",
                 z, lat, bus.o_x, bus.o_y, ex[31:0], ey[31:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    longint ax, ay, bx, by, ex, ey;
    int lat;
    logic [31:0] az, bz;
    ax = UNIT; ay = 0; az = 32'h20000000;
    bx = longint'($urandom_range(32'h20000000)) - 64'h10000000;
    by = longint'($urandom_range(32'h20000000)) - 64'h10000000;
    bz = $urandom;
    start_op(ax, ay, az);
    lat = 0;
    forever begin
      @(negedge clk);
      bus.i_start = 1'b0;
      if (bus.o_done || lat >= 40) break;
      if (lat == 3) begin
        checks++;
        if (bus.o_busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_mid got %b required 1", bus.o_busy);
        end
      end
      if (lat == 3 || lat == 10) begin
        bus.i_start = 1'b1;
        bus.ix = 32'h12345678;
        bus.iy = 32'h0ABCDEF0;
        bus.iz = $urandom;
      end
      @(posedge clk);
      lat++;
    end
    model(ax, ay, az, ex, ey);
    checks++;
    if (lat != 17 || absdiff(bus.o_x, ex) > TOL || absdiff(bus.o_y, ey) > TOL) begin
      errors++;
      $display("FAIL ignore_start lat=%0d got x=%h y=%h required lat=17 x~%h y~%h",
               lat, bus.o_x, bus.o_y, ex[31:0], ey[31:0]);
    end
    start_op(bx, by, bz);
    wait_done(lat);
    model(bx, by, bz, ex, ey);
    checks++;
    if (lat != 17 || absdiff(bus.o_x, ex) > TOL || absdiff(bus.o_y, ey) > TOL) begin
      errors++;
      $display("FAIL back_to_back lat=%0d got x=%h y=%h required lat=17 x~%h y~%h",
               lat, bus.o_x, bus.o_y, ex[31:0], ey[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation;
    int lat;
    start_op(64'h7FFFFFFF, 64'h7FFFFFFF, 32'h0);
    wait_done(lat);
    checks++;
    if (lat != 17 || bus.o_x !== 32'h7FFFFFFF || bus.o_y !== 32'h7FFFFFFF) begin
      errors++;
      $display("FAIL saturation lat=%0d got x=%h y=%h required 7fffffff 7fffffff",
               lat, bus.o_x, bus.o_y);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop;
    int lat;
    bit seen;
    longint ex, ey;
    start_op(UNIT, 0, 32'h40000000);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_x !== 32'd0 ||
        bus.o_y !== 32'd0 || bus.o_z !== 32'd0) begin
      errors++;
      $display("FAIL reset_midop busy=%b done=%b x=%h y=%h z=%h required all 0",
               bus.o_busy, bus.o_done, bus.o_x, bus.o_y, bus.o_z);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.o_done) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abandoned_done got done=1 required none");
    end
    start_op(UNIT, 0, 32'hC0000000);
    wait_done(lat);
    model(UNIT, 0, 32'hC0000000, ex, ey);
    checks++;
    if (lat != 17 || absdiff(bus.o_x, ex) > TOL || absdiff(bus.o_y, ey) > TOL) begin
      errors++;
      $display("FAIL after_reset lat=%0d got x=%h y=%h required lat=17 x~%h y~%h",
               lat, bus.o_x, bus.o_y, ex[31:0], ey[31:0]);
    end
    @(negedge clk);
  endtask

  initial begin
    k_gain = 1.0;
    for (int i = 0; i < 16; i++) k_gain = k_gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));
    bus.i_start = 1'b0;
    bus.ix = '0;
    bus.iy = '0;
    bus.iz = '0;
    #2;
    test_reset;
    test_rotation;
    test_random;
    test_back_to_back;
    test_saturation;
    test_reset_midop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
